fsm_stim_driver: RTL and testbench
==================================

// Module: fsm_stim_driver
// PURPOSE
//  Hardware stimulus source and target monitor for the 32-state lab FSM (ex4-class DUT).
//  Drives the DUT inputs X, Clear and C[31:0] from a seeded LFSR, one new vector per clock.
//  Watches the DUT one-hot state vector and reports the cycle count when it matches TARGET.
//  Reports a timeout instead if MAX_CYCLES elapse first. Sits beside the DUT in on-board self-test.
// PARAMETERS
//  SEED        34'h2_DEAD_BEEF  LFSR load value on reset; must be nonzero
//  TARGET      32'h0000_0080    one-hot state pattern that counts as reached
//  MAX_CYCLES  1_000_000        RUN cycles allowed before TIMEOUT; >=1, <2^33
// PORTS
//  CLK      in   1   clock; all logic on rising edge
//  Clear    in   1   synchronous, active-high reset
//  Start    in   1   pulse: begin/restart a run
//  S_i      in   32  DUT state bits {S31..S0}
//  X_o      out  1   drives DUT X
//  Clear_o  out  1   drives DUT Clear
//  C_o      out  32  drives DUT C_31..C_0
//  Busy     out  1   high in RUN
//  Hit      out  1   high in HIT (target reached), held until Start/Clear
//  Timeout  out  1   high in TIMEOUT, held until Start/Clear
//  Count    out  33  RUN cycles elapsed; frozen in HIT/TIMEOUT
// BEHAVIOUR
//  Reset (Clear=1): state IDLE; lfsr<=SEED; Count=0; X_o=Clear_o=0; C_o=0; Busy=Hit=Timeout=0.
//  Clear has priority over every other input, in any state (reset mid-run -> IDLE, next cycle).
//  States: IDLE, RUN, HIT, TIMEOUT (registered; outputs Moore, decoded from state).
//  IDLE/HIT/TIMEOUT + Start=1 -> RUN, Count<=0; lfsr NOT reloaded (continues sequence).
//  RUN, each edge, in priority order:
//   S_i==TARGET -> HIT, Count unchanged, lfsr holds.
//   else Count+1==MAX_CYCLES -> TIMEOUT, Count<=MAX_CYCLES.
//   else Count<=Count+1, lfsr advances one step.
//  Start while in RUN is ignored. Match beats timeout when both occur on the same edge.
//  LFSR: 34-bit Fibonacci, poly x^34+x^27+x^2+x+1, shift left, feedback into bit 0.
//  LFSR advances only on RUN edges that stay in RUN.
//  Outputs registered, valid only in RUN: C_o=lfsr[31:0], X_o=lfsr[32], Clear_o per CONFIGURATION.
//  Outside RUN: C_o, X_o and Clear_o are forced to 0.
//  Latency: DUT sees the vector one cycle after the LFSR step; S_i is sampled raw, not re-registered.
//  Count width 33 bits; it never wraps, because TIMEOUT fires first.
//  SEED==0 is illegal: flag it with a simulation-time $error; the LFSR would lock up at zero.
// CONFIGURATION
//  Macro FSM_STIM_CLEAR_THROTTLE_EN:
//   defined -> Clear_o=lfsr[33]&lfsr[1]&lfsr[0] (~1/8 duty), so deep states stay reachable.
//   undefined -> Clear_o=lfsr[33] (~1/2 duty, matches plain random stimulus).
// STRUCTURE
//  Shared package fsm_stim_pkg holds:
//   state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_HIT=2'd2, ST_TIMEOUT=2'd3;
//   LFSR_W=34 and tap positions {33,26,1,0}; the default TARGET constant.
//  Sub-module lfsr34: inputs CLK, Clear, load value, advance enable; output q[33:0].
//  Top level holds the FSM, Count, output muxing and the compare.
// TESTING
//  1 Reset: hold Clear 3 cycles, then 1 -> Busy=Hit=Timeout=0, Count=0, C_o=0, X_o=0.
//  2 Immediate hit: S_i=32'h80, pulse Start -> RUN 1 cycle, then Hit=1, Count=0.
//    Hit is held for 10 cycles with C_o=0.
//  3 Timeout: MAX_CYCLES=16, S_i=0 constant, Start -> Busy 16 cycles, then Timeout=1, Count=16.
//  4 LFSR model: SEED=34'h1, 40 RUN cycles -> C_o/X_o bit-exact vs software model of poly.
//  5 Reset mid-run: Clear=1 at Count=5 -> IDLE next edge, all outputs reset.
//    A following Start restarts from SEED.
//  6 Macro: 4096 RUN cycles -> Clear_o high count ~512 with FSM_STIM_CLEAR_THROTTLE_EN (±15%).
//    Same run without the macro -> Clear_o high count ~2048 (±15%).
//    Also check match-vs-timeout tie: S_i hits on cycle MAX_CYCLES-1 -> Hit=1, Timeout=0.

Source files
------------

// File: rtl/fsm_stim_pkg.sv
// Shared constants for the lab-FSM stimulus driver: state encoding, LFSR geometry and default target.
package fsm_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HIT     = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam int LFSR_W = 34;

    // x^34 + x^27 + x^2 + x + 1 -> taps at bit positions 33, 26, 1, 0
    localparam int TAP_A = 33;
    localparam int TAP_B = 26;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    localparam logic [31:0] TARGET_DEFAULT = 32'h0000_0080;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] q);
        return q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];
    endfunction

endpackage

// File: rtl/fsm_stim_driver_lfsr34.sv
// 34-bit Fibonacci LFSR, shift-left with feedback into bit 0; reloads on Clear, steps on adv_i.
module lfsr34
    import fsm_stim_pkg::*;
(
    input  logic              CLK,
    input  logic              Clear,
    input  logic [LFSR_W-1:0] load_i,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb(lfsr_q)};
        end
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            lfsr_q <= load_i;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/fsm_stim_driver.sv
// LFSR stimulus source and one-hot target monitor for the 32-state lab FSM.
// Optional macro FSM_STIM_CLEAR_THROTTLE_EN lowers the Clear_o duty to about 1/8.
module fsm_stim_driver
    import fsm_stim_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED       = 34'h2_DEAD_BEEF,
    parameter logic [31:0]       TARGET     = TARGET_DEFAULT,
    parameter logic [32:0]       MAX_CYCLES = 33'd1_000_000
) (
    input  logic        CLK,
    input  logic        Clear,
    input  logic        Start,
    input  logic [31:0] S_i,
    output logic        X_o,
    output logic        Clear_o,
    output logic [31:0] C_o,
    output logic        Busy,
    output logic        Hit,
    output logic        Timeout,
    output logic [32:0] Count
);

    if (SEED == '0) begin : g_seed_check
        $error("fsm_stim_driver: SEED must be nonzero, the LFSR would lock at zero");
    end

    state_t            state_q, state_d;
    logic [32:0]       count_q, count_d;
    logic              adv;
    logic [LFSR_W-1:0] lfsr;
    logic              clr_bit;
    logic              hit_now;
    logic              last_cycle;

    lfsr34 u_lfsr (
        .CLK    (CLK),
        .Clear  (Clear),
        .load_i (SEED),
        .adv_i  (adv),
        .q_o    (lfsr)
    );

    assign hit_now    = (S_i == TARGET);
    assign last_cycle = ((count_q + 33'd1) == MAX_CYCLES);

    always_ff @(posedge CLK) begin
        if (Clear) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Match is tested before the cycle limit so a same-edge tie reports HIT.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        adv     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hit_now) begin
                    state_d = ST_HIT;
                end else if (last_cycle) begin
                    state_d = ST_TIMEOUT;
                    count_d = MAX_CYCLES;
                end else begin
                    count_d = count_q + 33'd1;
                    adv     = 1'b1;
                end
            end
            default: begin
                if (Start) begin
                    state_d = ST_RUN;
                    count_d = '0;
                end
            end
        endcase
    end

`ifdef FSM_STIM_CLEAR_THROTTLE_EN
    assign clr_bit = lfsr[33] & lfsr[1] & lfsr[0];
`else
    assign clr_bit = lfsr[33];
`endif

    always_comb begin
        Busy    = 1'b0;
        Hit     = 1'b0;
        Timeout = 1'b0;
        C_o     = '0;
        X_o     = 1'b0;
        Clear_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                Busy    = 1'b1;
                C_o     = lfsr[31:0];
                X_o     = lfsr[32];
                Clear_o = clr_bit;
            end
            ST_HIT:     Hit     = 1'b1;
            ST_TIMEOUT: Timeout = 1'b1;
            default: ;
        endcase
    end

    assign Count = count_q;

endmodule

// File: tb/tb_fsm_stim_driver.sv
// Self-checking bench for fsm_stim_driver: directed steps plus randomized runs against a behavioural model.
module tb_fsm_stim_driver;

    localparam logic [33:0] SEED_A   = 34'h1;
    localparam logic [32:0] MAX_A    = 33'd16;
    localparam logic [33:0] SEED_B   = 34'h2_DEAD_BEEF;
    localparam logic [32:0] MAX_B    = 33'd5000;
    localparam logic [31:0] TGT      = 32'h0000_0080;
    // Polynomial x^34+x^27+x^2+x+1 as a tap mask over the state bits
    localparam logic [33:0] TAP_MASK = (34'd1 << 33) | (34'd1 << 26) | (34'd1 << 1) | 34'd1;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        clr_a, start_a, x_a, co_a, busy_a, hit_a, to_a;
    logic [31:0] s_a, c_a;
    logic [32:0] cnt_a;
    logic        clr_b, start_b, x_b, co_b, busy_b, hit_b, to_b;
    logic [31:0] s_b, c_b;
    logic [32:0] cnt_b;

    fsm_stim_driver #(.SEED(SEED_A), .TARGET(TGT), .MAX_CYCLES(MAX_A)) u_a (
        .CLK(CLK), .Clear(clr_a), .Start(start_a), .S_i(s_a),
        .X_o(x_a), .Clear_o(co_a), .C_o(c_a),
        .Busy(busy_a), .Hit(hit_a), .Timeout(to_a), .Count(cnt_a)
    );

    fsm_stim_driver #(.SEED(SEED_B), .TARGET(TGT), .MAX_CYCLES(MAX_B)) u_b (
        .CLK(CLK), .Clear(clr_b), .Start(start_b), .S_i(s_b),
        .X_o(x_b), .Clear_o(co_b), .C_o(c_b),
        .Busy(busy_b), .Hit(hit_b), .Timeout(to_b), .Count(cnt_b)
    );

    int          n_pass = 0;
    int          n_tot  = 0;
    logic [33:0] ml;
    logic [32:0] mcnt;
    logic        m_hit, m_to;

    function automatic logic [33:0] step(input logic [33:0] q);
        logic fb;
        fb = ^(q & TAP_MASK);
        return {q[32:0], fb};
    endfunction

    function automatic logic exp_clr(input logic [33:0] q);
`ifdef FSM_STIM_CLEAR_THROTTLE_EN
        return q[33] & q[1] & q[0];
`else
        return q[33];
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_busy"},  busy_a, 0);
        chk({tag, "_hit"},   hit_a,  0);
        chk({tag, "_to"},    to_a,   0);
        chk({tag, "_count"}, cnt_a,  0);
        chk({tag, "_c"},     c_a,    0);
        chk({tag, "_x"},     x_a,    0);
        chk({tag, "_clr"},   co_a,   0);
    endtask

    // One run on instance A; hit_at forces a match at that count, clear_at aborts with Clear.
    task automatic run_a(input int hit_at, input int clear_at, input int hit_pct);
        int          guard;
        logic [31:0] s;
        start_a = 1'b1;
        s_a     = '0;
        tick();
        start_a = 1'b0;
        mcnt    = '0;
        m_hit   = 1'b0;
        m_to    = 1'b0;
        guard   = 0;
        while (!m_hit && !m_to && guard < 40) begin
            guard++;
            chk("run_busy",  busy_a, 1);
            chk("run_count", cnt_a,  mcnt);
            chk("run_c",     c_a,    ml[31:0]);
            chk("run_x",     x_a,    ml[32]);
            chk("run_clr",   co_a,   exp_clr(ml));
            if (int'(mcnt) == clear_at) begin
                clr_a = 1'b1;
                s_a   = '0;
                tick();
                clr_a = 1'b0;
                chk_idle_a("midclr");
                ml = SEED_A;
                return;
            end
            s = $urandom;
            if (s == TGT) s = '0;
            if (int'(mcnt) == hit_at || int'($urandom_range(99, 0)) < hit_pct) s = TGT;
            s_a     = s;
            start_a = ($urandom_range(3, 0) == 0);
            tick();
            start_a = 1'b0;
            if (s == TGT) begin
                m_hit = 1'b1;
            end else if (mcnt + 33'd1 == MAX_A) begin
                m_to = 1'b1;
                mcnt = MAX_A;
            end else begin
                mcnt = mcnt + 33'd1;
                ml   = step(ml);
            end
        end
        chk("run_bound", guard < 40, 1);
        chk("end_hit",   hit_a,  m_hit);
        chk("end_to",    to_a,   m_to);
        chk("end_count", cnt_a,  mcnt);
        chk("end_busy",  busy_a, 0);
        chk("end_c",     c_a,    0);
        chk("end_x",     x_a,    0);
        s_a = '0;
    endtask

    initial begin
        int          hi, exp_hi, lo_lim, hi_lim;
        logic [33:0] mlb;

        clr_a = 1'b1; start_a = 1'b0; s_a = '0;
        clr_b = 1'b1; start_b = 1'b0; s_b = '0;
        ml = SEED_A;
        repeat (3) tick();
        chk_idle_a("reset");
        chk("reset_b_busy",  busy_b, 0);
        chk("reset_b_count", cnt_b,  0);
        clr_a = 1'b0;
        clr_b = 1'b0;
        tick();
        chk("idle_no_start", busy_a, 0);

        // Immediate hit, then the held HIT state
        s_a = TGT;
        run_a(0, -1, 0);
        repeat (10) begin
            tick();
            chk("hold_hit", hit_a, 1);
            chk("hold_c",   c_a,   0);
        end

        // Back-to-back timeouts; the LFSR sequence continues across runs
        repeat (3) run_a(-1, -1, 0);

        // Randomized runs with occasional matches
        repeat (6) run_a(-1, -1, 8);

        // Match on the last allowed cycle beats the timeout
        run_a(int'(MAX_A) - 1, -1, 0);
        chk("tie_hit",   hit_a, 1);
        chk("tie_to",    to_a,  0);
        chk("tie_count", cnt_a, MAX_A - 33'd1);

        // Clear mid-run, then a restart that begins again from SEED
        run_a(-1, 5, 0);
        run_a(-1, -1, 0);

        // Clear_o duty over a long run on instance B
        s_b     = '0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        mlb     = SEED_B;
        hi      = 0;
        exp_hi  = 0;
        for (int i = 0; i < 4096; i++) begin
            if (co_b) hi++;
            if (exp_clr(mlb)) exp_hi++;
            mlb = step(mlb);
            tick();
        end
`ifdef FSM_STIM_CLEAR_THROTTLE_EN
        lo_lim = 435;  hi_lim = 589;
`else
        lo_lim = 1741; hi_lim = 2355;
`endif
        chk("duty_exact",  hi, exp_hi);
        chk("duty_range",  (hi >= lo_lim) && (hi <= hi_lim), 1);
        chk("long_count",  cnt_b,  4096);
        chk("long_busy",   busy_b, 1);
        chk("long_c",      c_b,    mlb[31:0]);
        chk("long_x",      x_b,    mlb[32]);
        chk("long_nohit",  hit_b,  0);
        chk("long_noto",   to_b,   0);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("b_clear_busy",  busy_b, 0);
        chk("b_clear_count", cnt_b,  0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
